corejtagdebug_tgt_sched: RTL and testbench

- Target scheduler for the multi-target JTAG debug tunnel.
- Adds a dedicated select data register to the UJTAG user-IR space. Through it the host picks which debug target's tunnel controller may run.
- Produces a one-hot per-target enable used to gate each target's TCK and UTDODRV.
- Never switches targets while a tunnel packet is in flight, and inserts a guard interval between deselecting one target and granting the next.

---
 rtl/corejtagdebug_pkg.sv | 40 ++++
 rtl/corejtagdebug_sel_dr.sv | 46 ++++
 rtl/corejtagdebug_tgt_sched.sv | 153 +++++++++++++++
 tb/tb_corejtagdebug_tgt_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/corejtagdebug_pkg.sv
// Shared types for the multi-target JTAG debug tunnel scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package corejtagdebug_pkg;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GUARD = 2'd3
  } sched_st_t;

  // Select-DR bit positions (update view)
  localparam int DR_W       = 8;
  localparam int DR_EN      = 7;
  localparam int DR_LOCK    = 6;
  localparam int DR_ERR_CLR = 5;
  localparam int DR_IDX_HI  = 3;
  localparam int DR_IDX_LO  = 0;
  localparam int IDX_W      = 4;
  localparam int MAX_TGTS   = 16;

  // Capture view of the select DR, MSB first
  typedef struct packed {
    logic             busy_any;
    logic             lock;
    logic             err;
    logic             pend_vld;
    logic [IDX_W-1:0] sel_idx;
  } cap_word_t;

  function automatic logic [MAX_TGTS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [MAX_TGTS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/corejtagdebug_sel_dr.sv
// Scheduler select DR: 8-bit capture/shift/update register in the UJTAG user-IR space.
// Latency: capture/shift take effect on the UDRCK edge; upd_stb is combinational during update-DR.
// Backpressure: none; the TAP controller paces every access.
// Ports: clk/rst_n; sel_hit gates all actions; cap/sh/upd TAP states; tdi serial in;
//        cap_word loaded on capture; tdo = LSB; upd_stb plus decoded en/lock_req/err_clr/idx.
module corejtagdebug_sel_dr
  import corejtagdebug_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel_hit,
  input  logic             cap,
  input  logic             sh,
  input  logic             upd,
  input  logic             tdi,
  input  cap_word_t        cap_word,
  output logic             tdo,
  output logic             upd_stb,
  output logic             en,
  output logic             lock_req,
  output logic             err_clr,
  output logic [IDX_W-1:0] idx
);

  logic [DR_W-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (sel_hit) begin
      if (cap) begin
        sr <= cap_word;
      end else if (sh) begin
        sr <= {tdi, sr[DR_W-1:1]};  // LSB-first
      end
    end
  end

  assign tdo      = sr[0];
  assign upd_stb  = sel_hit & upd;
  assign en       = sr[DR_EN];
  assign lock_req = sr[DR_LOCK];
  assign err_clr  = sr[DR_ERR_CLR];
  assign idx      = sr[DR_IDX_HI:DR_IDX_LO];

endmodule

// File: rtl/corejtagdebug_tgt_sched.sv
// Target scheduler: grants one debug target's tunnel controller at a time via a select DR.
// Latency: grant GUARD_CYCLES+1 edges after update from idle, GUARD_CYCLES+2 from an idle grant.
// Backpressure: a switch waits for the granted target's TGT_BUSY to drop before deselecting.
// Ports: UDRCK/URSTB clock and async reset; UDRCAP/UDRSH/UDRUPD/UIREG/UTDI from UJTAG;
//        TGT_BUSY per-target packet in flight; TGT_EN one-hot grant; UTDO/UTDODRV scheduler DR out.
module corejtagdebug_tgt_sched
  import corejtagdebug_pkg::*;
#(
  parameter int          NUM_DEBUG_TGTS = 16,
  parameter logic [7:0]  IR_CODE_SEL    = 8'h50,
  parameter int          GUARD_CYCLES   = 4
) (
  input  logic                      UDRCK,
  input  logic                      URSTB,
  input  logic                      UDRCAP,
  input  logic                      UDRSH,
  input  logic                      UDRUPD,
  input  logic [7:0]                UIREG,
  input  logic                      UTDI,
  input  logic [NUM_DEBUG_TGTS-1:0] TGT_BUSY,
  output logic [NUM_DEBUG_TGTS-1:0] TGT_EN,
  output logic                      UTDO,
  output logic                      UTDODRV
);

  sched_st_t        state;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] pend_idx;
  logic [IDX_W-1:0] nxt_idx;   // target latched on GUARD entry
  logic             pend_en;
  logic             pend_vld;
  logic             lock;
  logic             err;
  logic [3:0]       guard_cnt;

  logic             sel_hit;
  logic             sr_tdo;
  logic             upd_stb;
  logic             upd_en;
  logic             upd_lock_req;
  logic             upd_err_clr;
  logic [IDX_W-1:0] upd_idx;
  logic             idx_bad;
  cap_word_t        cap_word;
  logic [MAX_TGTS-1:0] busy_ext;
  logic [MAX_TGTS-1:0] nxt_oh;

  assign sel_hit = (UIREG == IR_CODE_SEL);
  assign UTDODRV = sel_hit;
  assign UTDO    = sel_hit & sr_tdo;

  assign cap_word.busy_any = |TGT_BUSY;
  assign cap_word.lock     = lock;
  assign cap_word.err      = err;
  assign cap_word.pend_vld = pend_vld;
  assign cap_word.sel_idx  = sel_idx;

  // Zero-extend so a 4-bit index is always in range
  assign busy_ext = MAX_TGTS'(TGT_BUSY);
  assign nxt_oh   = idx_onehot(nxt_idx);
  assign idx_bad  = upd_en & ({1'b0, upd_idx} >= 5'(NUM_DEBUG_TGTS));

  corejtagdebug_sel_dr u_sel_dr (
    .clk      (UDRCK),
    .rst_n    (URSTB),
    .sel_hit  (sel_hit),
    .cap      (UDRCAP),
    .sh       (UDRSH),
    .upd      (UDRUPD),
    .tdi      (UTDI),
    .cap_word (cap_word),
    .tdo      (sr_tdo),
    .upd_stb  (upd_stb),
    .en       (upd_en),
    .lock_req (upd_lock_req),
    .err_clr  (upd_err_clr),
    .idx      (upd_idx)
  );

  always_ff @(posedge UDRCK or negedge URSTB) begin
    if (!URSTB) begin
      state     <= ST_OFF;
      sel_idx   <= '0;
      pend_idx  <= '0;
      nxt_idx   <= '0;
      pend_en   <= 1'b0;
      pend_vld  <= 1'b0;
      lock      <= 1'b0;
      err       <= 1'b0;
      guard_cnt <= '0;
      TGT_EN    <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          TGT_EN <= '0;
          if (pend_vld) begin
            pend_vld <= 1'b0;
            if (pend_en) begin
              state     <= ST_GUARD;
              guard_cnt <= 4'(GUARD_CYCLES - 1);
              nxt_idx   <= pend_idx;
            end
          end
        end
        ST_GRANT: begin
          if (pend_vld) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Only the granted target's busy matters; others are ignored
          if (!busy_ext[sel_idx]) begin
            pend_vld <= 1'b0;
            TGT_EN   <= '0;
            if (pend_en) begin
              state     <= ST_GUARD;
              guard_cnt <= 4'(GUARD_CYCLES - 1);
              nxt_idx   <= pend_idx;
            end else begin
              state <= ST_OFF;
            end
          end
        end
        ST_GUARD: begin
          if (guard_cnt == '0) begin
            state   <= ST_GRANT;
            sel_idx <= nxt_idx;
            TGT_EN  <= nxt_oh[NUM_DEBUG_TGTS-1:0];
          end else begin
            guard_cnt <= guard_cnt - 4'd1;
          end
        end
        default: state <= ST_OFF;
      endcase

      // Placed after the FSM so a same-cycle update wins over pend_vld being consumed
      if (upd_stb) begin
        if (upd_err_clr) err <= 1'b0;
        if (!lock) begin
          if (idx_bad) begin
            err <= 1'b1;
          end else begin
            pend_idx <= upd_idx;
            pend_en  <= upd_en;
            pend_vld <= 1'b1;
            lock     <= upd_lock_req;
          end
        end
      end
    end
  end

  a_en_onehot0 : assert property (@(posedge UDRCK) disable iff (!URSTB) $onehot0(TGT_EN));

endmodule

// File: tb/tb_corejtagdebug_tgt_sched.sv
module tb_corejtagdebug_tgt_sched;
  localparam int GC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cap = 1'b0, sh = 1'b0, upd = 1'b0, tdi = 1'b0;
  logic [7:0]  ir = 8'h00;
  logic [15:0] busy = '0;
  logic [15:0] en0;
  logic [7:0]  en1;
  logic        tdo0, drv0, tdo1, drv1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  corejtagdebug_tgt_sched #(.NUM_DEBUG_TGTS(16), .IR_CODE_SEL(8'h50), .GUARD_CYCLES(GC)) dut0 (
    .UDRCK(clk), .URSTB(rst_n), .UDRCAP(cap), .UDRSH(sh), .UDRUPD(upd), .UIREG(ir),
    .UTDI(tdi), .TGT_BUSY(busy), .TGT_EN(en0), .UTDO(tdo0), .UTDODRV(drv0));

  corejtagdebug_tgt_sched #(.NUM_DEBUG_TGTS(8), .IR_CODE_SEL(8'h51), .GUARD_CYCLES(GC)) dut1 (
    .UDRCK(clk), .URSTB(rst_n), .UDRCAP(cap), .UDRSH(sh), .UDRUPD(upd), .UIREG(ir),
    .UTDI(tdi), .TGT_BUSY(busy[7:0]), .TGT_EN(en1), .UTDO(tdo1), .UTDODRV(drv1));

  typedef struct {
    logic [15:0] val;
    int          at;
  } en_exp_t;

  en_exp_t    q0[$];
  logic [7:0] qcap[$];
  int         checks = 0;
  int         passes = 0;
  bit         sb_on = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic exp_en(input logic [15:0] v, input int at);
    en_exp_t e;
    e.val = v;
    e.at  = at;
    q0.push_back(e);
  endtask

  // Monitor: TGT_EN change scoreboard, capture-word scoreboard, grant properties
  logic [15:0] last0 = '0;
  logic [7:0]  last1 = '0;
  logic [7:0]  capbits;
  int          nb = 0;
  int          zcyc = 0;

  always @(negedge clk) begin
    en_exp_t e;
    if (sb_on) begin
      if (en0 !== last0) begin
        if (q0.size() == 0) chk("en0_unexpected_change", en0, last0);
        else begin
          e = q0.pop_front();
          chk("en0_value", en0, e.val);
          chk("en0_cycle", cyc, e.at);
        end
      end
      if (en1 !== last1) chk("en1_unexpected_change", en1, last1);
      if (cap) nb = 0;
      else if (sh && (drv0 || drv1)) begin
        capbits[nb] = drv0 ? tdo0 : tdo1;
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (qcap.size() == 0) chk("capture_unexpected", capbits, 8'hxx);
          else chk("capture_word", capbits, qcap.pop_front());
        end
      end
    end
    chk("en0_onehot0", $onehot0(en0), 1);
    chk("en1_onehot0", $onehot0(en1), 1);
    if (en0 != '0 && last0 == '0) chk("guard_gap", (cyc - zcyc) >= GC, 1);
    if (en0 == '0 && last0 != '0) zcyc = cyc;
    last0 = en0;
    last1 = en1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One DR access: capture, 8 shifts (LSB first), optional update. c_upd = cycle count after update edge.
  task automatic dr_op(input logic [7:0] code, input logic [7:0] wd, input bit do_upd,
                       input bit selected, input logic [7:0] exp_cap, output int c_upd);
    ir  = code;
    cap = 1'b1;
    if (selected) qcap.push_back(exp_cap);
    tick();
    cap = 1'b0;
    sh  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tdi = wd[k];
      if (!selected) begin
        chk("utdodrv_unselected", drv0, 0);
        chk("utdo_unselected", tdo0, 0);
      end
      tick();
    end
    sh  = 1'b0;
    tdi = 1'b0;
    if (do_upd) begin
      upd = 1'b1;
      tick();
      upd = 1'b0;
    end
    c_upd = cyc;
    ir = 8'h00;
  endtask

  initial begin
    int c;
    int cb;
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("reset_en0", en0, 16'h0000);
    chk("reset_en1", en1, 8'h00);
    chk("reset_utdodrv", drv0, 0);
    chk("reset_utdo", tdo0, 0);
    rst_n = 1'b1;
    tick();

    // Grant target 3 from OFF: GUARD_CYCLES+1 edges after update
    dr_op(8'h50, 8'h83, 1'b1, 1'b1, 8'h00, c);
    exp_en(16'h0008, c + 5);
    repeat (8) tick();
    dr_op(8'h50, 8'h00, 1'b0, 1'b1, 8'h03, c);

    // Switch to 5 while target 3 busy: hold until busy drops, 4 zero cycles, then grant
    busy[3] = 1'b1;
    dr_op(8'h50, 8'h85, 1'b1, 1'b1, 8'h83, c);
    repeat (6) tick();
    chk("drain_hold", en0, 16'h0008);
    busy[3] = 1'b0;
    cb = cyc;
    exp_en(16'h0000, cb + 1);
    exp_en(16'h0020, cb + 5);
    repeat (8) tick();

    // Out-of-range index on an 8-target scheduler sets ERR; ERR_CLR clears it
    dr_op(8'h51, 8'h8C, 1'b1, 1'b1, 8'h00, c);
    dr_op(8'h51, 8'h00, 1'b0, 1'b1, 8'h20, c);
    dr_op(8'h51, 8'h20, 1'b1, 1'b1, 8'h20, c);
    repeat (2) tick();
    dr_op(8'h51, 8'h00, 1'b0, 1'b1, 8'h00, c);

    // Lock onto target 2 from an idle grant (GUARD_CYCLES+2), then a write of 6 is ignored
    dr_op(8'h50, 8'hC2, 1'b1, 1'b1, 8'h05, c);
    exp_en(16'h0000, c + 2);
    exp_en(16'h0004, c + 6);
    repeat (8) tick();
    dr_op(8'h50, 8'h86, 1'b1, 1'b1, 8'h42, c);
    repeat (6) tick();
    chk("locked_hold", en0, 16'h0004);
    dr_op(8'h50, 8'h00, 1'b0, 1'b1, 8'h42, c);

    // Async reset drops grant and lock at once
    exp_en(16'h0000, cyc);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_grant", en0, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    dr_op(8'h50, 8'h00, 1'b0, 1'b1, 8'h00, c);

    // Access under another target's IR code: scheduler DR neither drives nor changes
    dr_op(8'h10, 8'h83, 1'b1, 1'b0, 8'h00, c);
    repeat (8) tick();
    dr_op(8'h50, 8'h00, 1'b0, 1'b1, 8'h00, c);

    repeat (4) tick();
    chk("en_queue_drained", q0.size(), 0);
    chk("cap_queue_drained", qcap.size(), 0);

    // Random TAP traffic, busy and async reset pulses; properties checked by the monitor
    sb_on = 1'b0;
    for (int i = 0; i < 800; i++) begin
      int r;
      tick();
      ir  = ($urandom_range(0, 3) != 0) ? 8'h50 : 8'h10;
      r   = $urandom_range(0, 11);
      cap = (r == 0);
      sh  = (r >= 1 && r <= 6);
      upd = (r == 7 || r == 8);
      tdi = 1'($urandom);
      if ($urandom_range(0, 3) == 0) busy = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 70) == 0) begin
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
    end
    cap = 1'b0;
    sh  = 1'b0;
    upd = 1'b0;
    ir  = 8'h00;
    repeat (4) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
